// File: rtl/row_clear_scanner_if.sv
// Board-side bundle for row_clear_scanner: board occupancy and play handshake in,
// removal requests, garbage exchange and statistics out.
interface row_clear_scanner_if #(
    parameter int BLOCKS_ROW = 10,
    parameter int BLOCKS_COL = 20,
    parameter int BITS_Y_POS = 5
);
    logic                             state_rst;
    logic [BLOCKS_ROW*BLOCKS_COL-1:0] game_board;
    logic                             play_mode;
    logic                             attack_in;
    logic                             bomb_cleared;
    logic                             remove_row_en;
    logic [BITS_Y_POS-1:0]            remove_row_y;
    logic                             send_en;
    logic [BITS_Y_POS-1:0]            get_line;
    logic [3:0]                       bomb_pos;
    logic [15:0]                      lines_total;

    modport master (
        output state_rst, game_board, play_mode, attack_in, bomb_cleared,
        input  remove_row_en, remove_row_y, send_en, get_line, bomb_pos, lines_total
    );

    modport slave (
        input  state_rst, game_board, play_mode, attack_in, bomb_cleared,
        output remove_row_en, remove_row_y, send_en, get_line, bomb_pos, lines_total
    );
endinterface

// File: rtl/row_clear_scanner.sv
// Scans the playfield bottom-up for full rows, hands each one to the board
// controller for removal, and converts multi-row clears into garbage sent to the opponent.
module row_clear_scanner #(
    parameter int BLOCKS_ROW  = 10,
    parameter int BLOCKS_COL  = 20,
    parameter int BITS_Y_POS  = 5,
    parameter int MAX_GARBAGE = 4,
    parameter int SEND_GAP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    row_clear_scanner_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        HOLD,
        WAIT_PLAY,
        SEND
    } state_t;

    localparam int                    NUM_IDX     = 2 ** BITS_Y_POS;
    localparam int                    GAP_W       = (SEND_GAP < 1) ? 1 : $clog2(SEND_GAP + 1);
    localparam logic [GAP_W-1:0]      GAP_LOAD    = GAP_W'(SEND_GAP);
    localparam logic [BITS_Y_POS-1:0] LAST_ROW    = BITS_Y_POS'(BLOCKS_COL - 1);
    localparam logic [BITS_Y_POS-1:0] GARBAGE_MAX = BITS_Y_POS'(MAX_GARBAGE);
    localparam logic [BITS_Y_POS-1:0] Y_ONE       = BITS_Y_POS'(1);
    localparam logic [4:0]            ROW_CELLS   = 5'(BLOCKS_ROW);

    state_t                state_q, state_d;
    logic [BITS_Y_POS-1:0] ptr_q, ptr_d;
    logic [2:0]            pend_q, pend_d;
    logic [2:0]            sends_left_q, sends_left_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  send_en_q, send_en_d;
    logic                  rem_en_q, rem_en_d;
    logic [BITS_Y_POS-1:0] rem_y_q, rem_y_d;
    logic [15:0]           lines_q, lines_d;
    logic [BITS_Y_POS-1:0] get_line_q;
    logic [3:0]            lfsr;
    logic [3:0]            bomb_pos_q;
    logic [3:0]            lfsr_m1;
    logic [3:0]            bomb_next;
    logic [BITS_Y_POS-1:0] bottom_row;
    logic [NUM_IDX-1:0]    row_full;

    // Padding the full-row vector to the whole index space keeps any ptr value a safe index.
    for (genvar r = 0; r < NUM_IDX; r++) begin : g_row
        if (r < BLOCKS_COL) begin : g_real
            assign row_full[r] = &bus.game_board[r*BLOCKS_ROW +: BLOCKS_ROW];
        end else begin : g_pad
            assign row_full[r] = 1'b0;
        end
    end

    assign bottom_row = LAST_ROW - get_line_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        pend_d       = pend_q;
        sends_left_d = sends_left_q;
        gap_d        = gap_q;
        send_en_d    = 1'b0;
        rem_y_d      = rem_y_q;
        lines_d      = lines_q;
        case (state_q)
            IDLE: begin
                if (bus.play_mode) begin
                    state_d = SCAN;
                    ptr_d   = bottom_row;
                end
            end
            SCAN: begin
                // Garbage can arrive mid-pass; rows it now covers must not be reported.
                if (!bus.play_mode) begin
                    state_d = IDLE;
                end else if (ptr_q > bottom_row) begin
                    ptr_d = bottom_row;
                end else if (row_full[ptr_q]) begin
                    state_d = HOLD;
                    rem_y_d = ptr_q;
                end else if (ptr_q == '0) begin
                    if (pend_q >= 3'd2) begin
                        state_d      = SEND;
                        sends_left_d = pend_q - 3'd1;
                        gap_d        = '0;
                    end else begin
                        pend_d = '0;
                        ptr_d  = bottom_row;
                    end
                end else begin
                    ptr_d = ptr_q - Y_ONE;
                end
            end
            HOLD: begin
                if (!bus.play_mode) begin
                    state_d = WAIT_PLAY;
                    lines_d = lines_q + 16'd1;
                    if (pend_q != 3'd7) begin
                        pend_d = pend_q + 3'd1;
                    end
                end
            end
            WAIT_PLAY: begin
                if (bus.play_mode) begin
                    state_d = SCAN;
                    ptr_d   = bottom_row;
                end
            end
            SEND: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (sends_left_q != 3'd0) begin
                    send_en_d    = 1'b1;
                    sends_left_d = sends_left_q - 3'd1;
                    gap_d        = GAP_LOAD;
                end else begin
                    pend_d  = '0;
                    state_d = SCAN;
                    ptr_d   = bottom_row;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rem_en_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            pend_q       <= '0;
            sends_left_q <= '0;
            gap_q        <= '0;
            send_en_q    <= 1'b0;
            rem_en_q     <= 1'b0;
            rem_y_q      <= '0;
            lines_q      <= '0;
        end else if (bus.state_rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            pend_q       <= '0;
            sends_left_q <= '0;
            gap_q        <= '0;
            send_en_q    <= 1'b0;
            rem_en_q     <= 1'b0;
            rem_y_q      <= '0;
            lines_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pend_q       <= pend_d;
            sends_left_q <= sends_left_d;
            gap_q        <= gap_d;
            send_en_q    <= send_en_d;
            rem_en_q     <= rem_en_d;
            rem_y_q      <= rem_y_d;
            lines_q      <= lines_d;
        end
    end

    // Hole column folds the 1..15 LFSR range onto the board width.
    assign lfsr_m1   = lfsr - 4'd1;
    assign bomb_next = ({1'b0, lfsr_m1} >= ROW_CELLS) ? (lfsr_m1 - ROW_CELLS[3:0]) : lfsr_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            get_line_q <= '0;
            lfsr       <= 4'b1001;
            bomb_pos_q <= 4'd8;
        end else if (bus.state_rst) begin
            get_line_q <= '0;
            lfsr       <= 4'b1001;
            bomb_pos_q <= 4'd8;
        end else begin
            lfsr       <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            bomb_pos_q <= bomb_next;
            if (bus.attack_in && !bus.bomb_cleared) begin
                if (get_line_q < GARBAGE_MAX) begin
                    get_line_q <= get_line_q + Y_ONE;
                end
            end else if (bus.bomb_cleared && !bus.attack_in) begin
                if (get_line_q != '0) begin
                    get_line_q <= get_line_q - Y_ONE;
                end
            end
        end
    end

    assign bus.remove_row_en = rem_en_q;
    assign bus.remove_row_y  = rem_y_q;
    assign bus.send_en       = send_en_q;
    assign bus.get_line      = get_line_q;
    assign bus.bomb_pos      = bomb_pos_q;
    assign bus.lines_total   = lines_q;

endmodule

// File: tb/tb_row_clear_scanner.sv
// Self-checking bench for row_clear_scanner: directed scenarios plus random play,
// all compared cycle by cycle against a behavioural model of the scanner's rules.
module tb_row_clear_scanner;

    localparam int W    = 10;
    localparam int H    = 20;
    localparam int Y    = 5;
    localparam int MAXG = 4;
    localparam int GAP  = 4;

    localparam int M_IDLE = 0;
    localparam int M_SCAN = 1;
    localparam int M_HOLD = 2;
    localparam int M_WAIT = 3;
    localparam int M_SEND = 4;

    logic clk;
    logic rst;
    logic [W-1:0] rows [H];

    int tests_run = 0;
    int failures  = 0;
    bit chk_en    = 1'b0;

    row_clear_scanner_if #(.BLOCKS_ROW(W), .BLOCKS_COL(H), .BITS_Y_POS(Y)) bif ();

    row_clear_scanner #(
        .BLOCKS_ROW(W), .BLOCKS_COL(H), .BITS_Y_POS(Y), .MAX_GARBAGE(MAXG), .SEND_GAP(GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < H; r++) begin
            bif.game_board[r*W +: W] = rows[r];
        end
    end

    // Behavioural model: pending sends are scheduled as absolute cycle numbers.
    int     m_mode, m_row, m_pend, m_get, m_rem_y;
    int     m_lines;
    bit     m_rem_en, m_send_en, m_fresh;
    longint cyc = 0;
    longint m_send_done;
    longint m_pulse_q[$];

    function automatic void model_reset();
        m_mode      = M_IDLE;
        m_row       = 0;
        m_pend      = 0;
        m_get       = 0;
        m_lines     = 0;
        m_rem_y     = 0;
        m_rem_en    = 1'b0;
        m_send_en   = 1'b0;
        m_fresh     = 1'b1;
        m_send_done = -1;
        m_pulse_q.delete();
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int bottom;
        cyc = cyc + 1;
        if (rst || bif.state_rst) begin
            model_reset();
        end else begin
            bottom    = H - 1 - m_get;
            m_send_en = 1'b0;
            m_fresh   = 1'b0;
            case (m_mode)
                M_IDLE: if (bif.play_mode) begin m_mode = M_SCAN; m_row = bottom; end
                M_SCAN: begin
                    if (!bif.play_mode) m_mode = M_IDLE;
                    else if (m_row > bottom) m_row = bottom;
                    else if (rows[m_row] == '1) begin m_mode = M_HOLD; m_rem_y = m_row; end
                    else if (m_row == 0) begin
                        if (m_pend >= 2) begin
                            m_mode = M_SEND;
                            for (int k = 0; k < m_pend - 1; k++) m_pulse_q.push_back(cyc + 1 + k * (GAP + 1));
                            m_send_done = cyc + 1 + (m_pend - 1) * (GAP + 1);
                        end else begin
                            m_pend = 0;
                            m_row  = bottom;
                        end
                    end else m_row = m_row - 1;
                end
                M_HOLD: if (!bif.play_mode) begin
                    m_mode  = M_WAIT;
                    m_pend  = (m_pend < 7) ? m_pend + 1 : 7;
                    m_lines = (m_lines + 1) % 65536;
                end
                M_WAIT: if (bif.play_mode) begin m_mode = M_SCAN; m_row = bottom; end
                default: begin
                    if (m_pulse_q.size() != 0 && m_pulse_q[0] == cyc) begin
                        m_send_en = 1'b1;
                        void'(m_pulse_q.pop_front());
                    end
                    if (cyc == m_send_done) begin m_mode = M_SCAN; m_row = bottom; m_pend = 0; end
                end
            endcase
            if (bif.attack_in && !bif.bomb_cleared) m_get = (m_get < MAXG) ? m_get + 1 : MAXG;
            else if (bif.bomb_cleared && !bif.attack_in) m_get = (m_get > 0) ? m_get - 1 : 0;
            m_rem_en = (m_mode == M_HOLD);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check_output("remove_row_en", 32'(bif.remove_row_en), 32'(m_rem_en));
            check_output("remove_row_y", 32'(bif.remove_row_y), m_rem_y);
            check_output("send_en", 32'(bif.send_en), 32'(m_send_en));
            check_output("get_line", 32'(bif.get_line), m_get);
            check_output("lines_total", 32'(bif.lines_total), m_lines);
            check_output("bomb_pos_range", 32'(int'(bif.bomb_pos) < W), 32'd1);
            if (m_fresh) check_output("bomb_pos_reset", 32'(bif.bomb_pos), 32'd8);
        end
    end

    task automatic apply_stimulus(input bit play, input bit atk, input bit bmb, input bit srst);
        bif.play_mode    = play;
        bif.attack_in    = atk;
        bif.bomb_cleared = bmb;
        bif.state_rst    = srst;
        @(negedge clk);
        bif.attack_in    = 1'b0;
        bif.bomb_cleared = 1'b0;
        bif.state_rst    = 1'b0;
    endtask

    task automatic clear_board();
        for (int r = 0; r < H; r++) rows[r] = '0;
    endtask

    task automatic remove_row(input int y);
        for (int r = y; r > 0; r--) rows[r] = rows[r-1];
        rows[0] = '0;
    endtask

    task automatic wait_rem(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bif.remove_row_en) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_sends(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bif.send_en) n++;
        end
    endtask

    // One removal handshake: controller drops play_mode while the board shifts down.
    task automatic do_removal(input string tag, input int exp_y);
        bit seen;
        wait_rem(30, seen);
        check_output({tag, "_removal_seen"}, 32'(seen), 32'd1);
        check_output({tag, "_removal_y"}, 32'(bif.remove_row_y), exp_y);
        remove_row(int'(bif.remove_row_y));
        bif.play_mode = 1'b0;
        @(negedge clk);
        bif.play_mode = 1'b1;
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  got2;
        int  times[$];
        int  bvals[1000];
        int  hist[W];
        bit  srst, atk, bmb, play;

        model_reset();
        clear_board();
        rst = 1'b1;
        bif.state_rst = 1'b0; bif.play_mode = 1'b0; bif.attack_in = 1'b0; bif.bomb_cleared = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_remove_row_en", 32'(bif.remove_row_en), 32'd0);
        check_output("reset_send_en", 32'(bif.send_en), 32'd0);
        check_output("reset_get_line", 32'(bif.get_line), 32'd0);
        check_output("reset_lines_total", 32'(bif.lines_total), 32'd0);
        check_output("reset_bomb_pos", 32'(bif.bomb_pos), 32'd8);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single row clear: reported quickly, counted, never sent.
        rows[H-1] = '1;
        bif.play_mode = 1'b1;
        wait_rem(3, seen);
        check_output("t1_rem_within_3", 32'(seen), 32'd1);
        check_output("t1_rem_y", 32'(bif.remove_row_y), 32'd19);
        remove_row(H - 1);
        bif.play_mode = 1'b0;
        @(negedge clk);
        bif.play_mode = 1'b1;
        repeat (2) @(negedge clk);
        check_output("t1_rem_en_low", 32'(bif.remove_row_en), 32'd0);
        check_output("t1_lines_total", 32'(bif.lines_total), 32'd1);
        count_sends(30, n);
        check_output("t1_no_send", n, 32'd0);

        // Triple clear: three removals then two spaced garbage pulses.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        clear_board();
        rows[17] = '1; rows[18] = '1; rows[19] = '1;
        bif.play_mode = 1'b1;
        for (int k = 0; k < 3; k++) do_removal("t2", 19);
        times.delete();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bif.send_en) times.push_back(i);
        end
        check_output("t2_send_count", times.size(), 32'd2);
        if (times.size() == 2) check_output("t2_send_spacing_ok", 32'(times[1] - times[0] >= GAP + 1), 32'd1);
        check_output("t2_lines_total", 32'(bif.lines_total), 32'd3);
        count_sends(60, n);
        check_output("t2_pend_cleared_no_send", n, 32'd0);

        // Garbage counter saturation and floor.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("t4_get_line_2", 32'(bif.get_line), 32'd2);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        check_output("t4_both_unchanged", 32'(bif.get_line), 32'd2);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_output("t4_floor_zero", 32'(bif.get_line), 32'd0);

        // Rows hidden under garbage are never reported.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (6) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        check_output("t3_get_line_sat", 32'(bif.get_line), 32'd4);
        clear_board();
        rows[19] = '1;
        bif.play_mode = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (bif.remove_row_en) n++;
        end
        check_output("t3_row19_hidden", n, 32'd0);
        rows[15] = '1;
        do_removal("t3", 15);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Game-level clear in the middle of sending aborts remaining pulses.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        clear_board();
        for (int r = 16; r < H; r++) rows[r] = '1;
        bif.play_mode = 1'b1;
        for (int k = 0; k < 4; k++) do_removal("t5", 19);
        n = 0;
        got2 = 1'b0;
        for (int i = 0; i < 80 && !got2; i++) begin
            @(negedge clk);
            if (bif.send_en) n++;
            if (n == 2) got2 = 1'b1;
        end
        check_output("t5_second_pulse_seen", 32'(got2), 32'd1);
        bif.state_rst = 1'b1;
        @(negedge clk);
        bif.state_rst = 1'b0;
        check_output("t5_rem_en_reset", 32'(bif.remove_row_en), 32'd0);
        check_output("t5_rem_y_reset", 32'(bif.remove_row_y), 32'd0);
        check_output("t5_send_en_reset", 32'(bif.send_en), 32'd0);
        check_output("t5_get_line_reset", 32'(bif.get_line), 32'd0);
        check_output("t5_lines_reset", 32'(bif.lines_total), 32'd0);
        check_output("t5_bomb_reset", 32'(bif.bomb_pos), 32'd8);
        count_sends(40, n);
        check_output("t5_no_more_send", n, 32'd0);

        // Hole generator: 1000 cycles from reset, range, period and visit counts.
        bif.play_mode = 1'b0;
        clear_board();
        rst = 1'b1;
        @(negedge clk);
        check_output("t6_bomb_in_reset", 32'(bif.bomb_pos), 32'd8);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            bvals[i] = int'(bif.bomb_pos);
            check_output("t6_lfsr_nonzero", 32'(dut.lfsr != 4'd0), 32'd1);
            if (i >= 15) check_output("t6_bomb_period15", bvals[i], bvals[i-15]);
        end
        check_output("t6_first_bomb", bvals[0], 32'd8);
        for (int c = 0; c < W; c++) hist[c] = 0;
        for (int i = 1; i <= 15; i++) if (bvals[i] >= 0 && bvals[i] < W) hist[bvals[i]]++;
        for (int c = 0; c < W; c++) check_output($sformatf("t6_bomb_visits_%0d", c), hist[c], (c < 15 - W) ? 2 : 1);

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            srst = ($urandom_range(0, 299) == 0);
            atk  = ($urandom_range(0, 9) == 0);
            bmb  = ($urandom_range(0, 9) == 0);
            if (bif.remove_row_en && $urandom_range(0, 2) == 0) begin
                remove_row(int'(bif.remove_row_y));
                play = 1'b0;
            end else begin
                play = ($urandom_range(0, 15) != 0);
            end
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(0, H - 1);
                if ($urandom_range(0, 2) == 0) rows[n] = '1;
                else begin
                    rows[n] = W'($urandom);
                    if (rows[n] == '1) rows[n][0] = 1'b0;
                end
            end
            apply_stimulus(play, atk, bmb, srst);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/row_clear_scanner.md
ROW_CLEAR_SCANNER -- requirements
Module: row_clear_scanner

Interface
REQ-001 Parameter BLOCKS_ROW, default 10, sets cells per board row; legal range 8..16.
REQ-002 Parameter BLOCKS_COL, default 20, sets rows per board.
REQ-003 Parameter BITS_Y_POS, default 5, sets the row-index width.
REQ-004 Parameter MAX_GARBAGE, default 4, sets the saturation limit of get_line.
REQ-005 Parameter SEND_GAP, default 4, sets the minimum idle cycles between send_en pulses.
REQ-006 clk  in  1  system clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 state_rst  in  1  synchronous game-level clear, same effect as rst.
REQ-009 game_board  in  BLOCKS_ROW*BLOCKS_COL  occupancy; row r occupies bits [r*BLOCKS_ROW +: BLOCKS_ROW], row 0 is the top.
REQ-010 play_mode  in  1  high while the downstream controller is in play mode.
REQ-011 attack_in  in  1  one-cycle pulse meaning the opponent sent one garbage line.
REQ-012 bomb_cleared  in  1  one-cycle pulse meaning one garbage line was cleared.
REQ-013 remove_row_en  out  1  level request to remove row remove_row_y.
REQ-014 remove_row_y  out  BITS_Y_POS  index of the full row.
REQ-015 send_en  out  1  one-cycle pulse, one per garbage line sent to the opponent.
REQ-016 get_line  out  BITS_Y_POS  count of garbage rows currently at the board bottom.
REQ-017 bomb_pos  out  4  column of the next garbage hole, range 0..BLOCKS_ROW-1.
REQ-018 lines_total  out  16  total rows removed since reset, wrapping modulo 2^16.

Function
REQ-019 The FSM SHALL use states IDLE, SCAN, HOLD, WAIT_PLAY and SEND.
REQ-020 IDLE SHALL go to SCAN when play_mode=1, loading ptr = BLOCKS_COL-1-get_line (the bottom clearable row).
REQ-021 In SCAN, each cycle SHALL test row ptr; if all BLOCKS_ROW bits of that row are 1, go to HOLD; otherwise decrement ptr.
REQ-022 In SCAN, when ptr=0 and row 0 is not full, go to SEND if pend>=2, else stay in SCAN and reload ptr to the bottom clearable row.
REQ-023 In SCAN, play_mode=0 SHALL abort to IDLE, leaving pend unchanged.
REQ-024 HOLD SHALL drive remove_row_en=1 with remove_row_y=ptr held stable, until play_mode=0.
REQ-025 The HOLD -> WAIT_PLAY transition SHALL increment pend (3-bit, saturating at 7) and lines_total.
REQ-026 WAIT_PLAY SHALL drive remove_row_en=0 and go to SCAN, with ptr reloaded, when play_mode=1.
REQ-027 SEND SHALL emit pend-1 send_en pulses, each followed by at least SEND_GAP low cycles, then clear pend and go to SCAN with ptr reloaded.
REQ-028 SEND SHALL ignore play_mode.
REQ-029 Rows with index > BLOCKS_COL-1-get_line SHALL never be reported as removable.
REQ-030 A single-row clear (pend=1 at the end of a pass) SHALL clear pend without sending.
REQ-031 get_line SHALL increment on attack_in, saturating at MAX_GARBAGE.
REQ-032 get_line SHALL decrement on bomb_cleared, with a floor of 0.
REQ-033 When attack_in and bomb_cleared are both high in the same cycle, get_line SHALL be unchanged.
REQ-034 lfsr SHALL be a 4-bit register with taps x^4+x^3+1, advancing every cycle, never 0.
REQ-035 bomb_pos SHALL be v=lfsr-1, minus BLOCKS_ROW when v>=BLOCKS_ROW, registered.
REQ-036 All outputs SHALL be registered; the first remove_row_en SHALL rise no later than BLOCKS_COL+2 cycles after play_mode rises.

Reset
REQ-037 rst or state_rst SHALL set state=IDLE, ptr=0, pend=0, remove_row_en=0, remove_row_y=0, send_en=0, get_line=0, lines_total=0, lfsr=4'b1001, bomb_pos=8, and clear the SEND gap counter.
REQ-038 state_rst in HOLD or SEND SHALL abort immediately with no further pulses.

Verification
REQ-039 Bench: play_mode=1, row 19 full -> remove_row_en=1, remove_row_y=19 within 3 cycles; play_mode pulsed low then high -> remove_row_en=0, lines_total=1, no send_en.
REQ-040 Bench: rows 17,18,19 full; the removal handshake modelled (board shifts down, row 19 stays full until 3 rows are gone) -> 3 removals reported, then exactly 2 send_en pulses spaced >= SEND_GAP+1 cycles, then pend=0.
REQ-041 Bench: 6 attack_in pulses -> get_line=4; row 19 full -> never reported; row 15 full -> remove_row_y=15.
REQ-042 Bench: attack_in and bomb_cleared in the same cycle at get_line=2 -> get_line=2; bomb_cleared at get_line=0 -> stays 0.
REQ-043 Bench: run 1000 cycles after rst -> bomb_pos always < 10 and lfsr never 0.
REQ-044 Bench: state_rst during the second SEND pulse gap -> no further send_en, and all outputs at reset values on the next cycle.
